// File: rtl/cpu_pkg.sv
// Shared opcode/state encodings and width derivations for the parameterised multicycle CPU.
package cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_LDI  = 3'd4,
        OP_JMP  = 3'd5,
        OP_BZ   = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    function automatic int f_ra_w(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int f_pc_w(input int imem_depth);
        return $clog2(imem_depth);
    endfunction

    function automatic int f_instr_w(input int ra_w);
        return OPCODE_W + 3 * ra_w;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: one write port, two operand read ports and a debug read port, async reset.
module cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RA_W   = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RA_W-1:0]   i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [RA_W-1:0]   i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [RA_W-1:0]   i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_regs [NREGS];

    // Register storage; reads are combinational so a same-cycle write shows the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/param_multicycle_cpu.sv
// Parameterised multicycle CPU: FETCH/DECODE/EXEC/WB sequencer over a writable instruction
// memory that survives reset, with a separate register file.
module param_multicycle_cpu
    import cpu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREGS      = 4,
    parameter  int IMEM_DEPTH = 16,
    localparam int RA_W       = f_ra_w(NREGS),
    localparam int PC_W       = f_pc_w(IMEM_DEPTH),
    localparam int INSTR_W    = f_instr_w(RA_W)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [RA_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               zero_flag,
    output logic               wb_valid,
    output logic [RA_W-1:0]    wb_addr,
    output logic [DATA_W-1:0]  wb_data
);

    if (PC_W > 3 * RA_W) begin : g_bad_pc_w
        $error("param_multicycle_cpu: PC_W exceeds the 3*RA_W jump target field");
    end
    if (DATA_W < 4) begin : g_bad_data_w
        $error("param_multicycle_cpu: DATA_W must be at least 4");
    end
    if ((NREGS < 4) || ((32'd1 << RA_W) != NREGS)) begin : g_bad_nregs
        $error("param_multicycle_cpu: NREGS must be a power of two >= 4");
    end

    state_e             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic               r_zero;
    logic               r_wb_valid;
    logic [RA_W-1:0]    r_wb_addr;
    logic [DATA_W-1:0]  r_wb_data;
    logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];

    opcode_e            w_opcode;
    logic [RA_W-1:0]    w_rs1;
    logic [RA_W-1:0]    w_rs2;
    logic [RA_W-1:0]    w_rd;
    logic [DATA_W-1:0]  w_imm;
    logic [PC_W-1:0]    w_target;
    logic [PC_W-1:0]    w_pc_inc;
    logic [DATA_W-1:0]  w_rdata_a;
    logic [DATA_W-1:0]  w_rdata_b;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_prog_ok;
    logic               w_rf_we;

    assign w_opcode  = opcode_e'(r_ir[INSTR_W-1 -: OPCODE_W]);
    assign w_rs1     = r_ir[3*RA_W-1 -: RA_W];
    assign w_rs2     = r_ir[2*RA_W-1 -: RA_W];
    assign w_rd      = r_ir[RA_W-1:0];
    assign w_imm     = DATA_W'({w_rs1, w_rs2});
    assign w_target  = PC_W'({w_rs1, w_rs2, w_rd});
    assign w_pc_inc  = r_pc + PC_W'(1'b1);
    assign w_prog_ok = (r_state == ST_IDLE) || (r_state == ST_HALT);
    assign w_rf_we   = (r_state == ST_WB);

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_rf_we),
        .i_waddr    (r_wb_addr),
        .i_wdata    (r_wb_data),
        .i_raddr_a  (w_rs1),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (w_rs2),
        .o_rdata_b  (w_rdata_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Program loading; deliberately outside the reset domain so a reset can rerun the image.
    always_ff @(posedge clk) begin
        if (prog_we && w_prog_ok) begin
            r_imem[prog_addr] <= prog_data;
        end
    end

    // ALU result for arithmetic/logic ops and LDI, wrapping at DATA_W bits.
    always_comb begin
        w_alu_res = {DATA_W{1'b0}};
        case (w_opcode)
            OP_ADD:  w_alu_res = r_op_a + r_op_b;
            OP_SUB:  w_alu_res = r_op_a - r_op_b;
            OP_AND:  w_alu_res = r_op_a & r_op_b;
            OP_OR:   w_alu_res = r_op_a | r_op_b;
            OP_LDI:  w_alu_res = w_imm;
            default: w_alu_res = {DATA_W{1'b0}};
        endcase
    end

    // Instruction sequencer; wb_valid is high exactly for the WB cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= {PC_W{1'b0}};
            r_ir       <= {INSTR_W{1'b0}};
            r_op_a     <= {DATA_W{1'b0}};
            r_op_b     <= {DATA_W{1'b0}};
            r_zero     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= {RA_W{1'b0}};
            r_wb_data  <= {DATA_W{1'b0}};
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_pc    <= {PC_W{1'b0}};
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= r_imem[r_pc];
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_op_a <= w_rdata_a;
                    r_op_b <= w_rdata_b;
                    if (w_opcode == OP_HALT) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_opcode)
                        OP_JMP: begin
                            r_pc    <= w_target;
                            r_state <= ST_FETCH;
                        end
                        OP_BZ: begin
                            r_pc    <= r_zero ? w_target : w_pc_inc;
                            r_state <= ST_FETCH;
                        end
                        default: begin
                            r_zero     <= (w_alu_res == {DATA_W{1'b0}});
                            r_wb_valid <= 1'b1;
                            r_wb_addr  <= w_rd;
                            r_wb_data  <= w_alu_res;
                            r_state    <= ST_WB;
                        end
                    endcase
                end
                ST_WB: begin
                    r_pc    <= w_pc_inc;
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign state     = r_state;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                       (r_state == ST_EXEC)  || (r_state == ST_WB);
    assign halted    = (r_state == ST_HALT);
    assign zero_flag = r_zero;
    assign wb_valid  = r_wb_valid;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;

endmodule
